mem_lsu: RTL and testbench

- MEM-stage load/store unit. Consumes the EX/MEM pipeline register outputs and drives the data-memory request/ready bus.
- Builds byte enables and shifted store data; aligns and sign/zero-extends load data.
- Stalls the front of the pipeline while a memory access is outstanding.
- Contains the MEM/WB pipeline register, whose outputs feed writeback and the forwarding path.

---
 rtl/mem_lsu_pkg.sv | 43 ++++
 rtl/mem_lsu_if.sv | 15 +
 rtl/mem_lsu_load_ext.sv | 26 ++
 rtl/mem_lsu.sv | 163 ++++++++++++++++
 tb/tb_mem_lsu.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared encodings and decode helpers for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_NOP   = 7'b0000000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // funct3[1:0] doubles as the access size for both loads and stores
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} acc_size_e;

  function automatic logic is_wb_op(logic [6:0] op);
    return op inside {OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
  endfunction

  function automatic logic f3_legal(logic is_load, logic [2:0] f3);
    if (is_load) return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction

  function automatic logic is_aligned(logic [1:0] sz, logic [1:0] lo);
    case (sz)
      SZ_B:    return 1'b1;
      SZ_H:    return ~lo[0];
      default: return lo == 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory request/ready bus between the LSU (master) and memory (slave).
interface mem_lsu_if #(parameter int XLEN = 32);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ready;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  input  dmem_rdata, dmem_ready);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  output dmem_rdata, dmem_ready);
endinterface

// File: rtl/mem_lsu_load_ext.sv
// Load lane select plus sign/zero extension; purely combinational.
module mem_load_ext
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[{offset_i, 3'b000} +: 8];
    h = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){b[7]}}, b};
      F3_H:    data_o = {{(XLEN-16){h[15]}}, h};
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, b};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, h};
      default: data_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// MEM stage: issues one blocking data-memory access at a time, stalls the
// front end while it is outstanding, and owns the MEM/WB register.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] alu_out_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] rs2_data_i,
  mem_lsu_if.master       dmem,
  output logic            stall_o,
  output logic            wb_we_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            lsu_err_o
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic [1:0]      off_q, off_d;
  logic            err_q, err_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic            is_ld, is_st, is_mem, go, bad, acc, tmo_hit;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata, ld_data;

  assign is_ld  = opcode_i == OPC_LOAD;
  assign is_st  = opcode_i == OPC_STORE;
  assign is_mem = is_ld | is_st;
  assign go     = is_mem & f3_legal(is_ld, funct3_i) & is_aligned(funct3_i[1:0], alu_out_i[1:0]);
  assign bad    = is_mem & ~go;
  assign acc    = state_q == ST_ACCESS;
  assign tmo_hit = (TIMEOUT > 0) && (tmo_q == TMO_LAST);

  always_comb begin
    case (acc_size_e'(funct3_i[1:0]))
      SZ_B:    begin st_be = 4'b0001 << alu_out_i[1:0]; st_wdata = {(XLEN/8){rs2_data_i[7:0]}};   end
      SZ_H:    begin st_be = 4'b0011 << alu_out_i[1:0]; st_wdata = {(XLEN/16){rs2_data_i[15:0]}}; end
      default: begin st_be = 4'b1111;                   st_wdata = rs2_data_i;                     end
    endcase
  end

  mem_load_ext #(.XLEN(XLEN)) u_ext (
    .rdata_i  (dmem.dmem_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    off_d     = off_q;
    err_d     = 1'b0;
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_ACCESS;
          tmo_d   = '0;
          addr_d  = {alu_out_i[XLEN-1:2], 2'b00};
          be_d    = is_st ? st_be : 4'b0000;
          wdata_d = is_st ? st_wdata : '0;
          we_d    = is_st;
          f3_d    = funct3_i;
          rd_d    = rd_i;
          off_d   = alu_out_i[1:0];
        end else if (bad) begin
          err_d = 1'b1;
        end else begin
          wb_we_d   = is_wb_op(opcode_i) & (rd_i != 5'd0);
          wb_rd_d   = rd_i;
          wb_data_d = alu_out_i;
        end
      end
      default: begin
        if (dmem.dmem_ready) begin
          state_d = ST_IDLE;
          if (!we_q) begin
            wb_we_d   = rd_q != 5'd0;
            wb_rd_d   = rd_q;
            wb_data_d = ld_data;
          end
        end else if (tmo_hit) begin
          // abandon the access; memory side must tolerate the dropped request
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      rd_q      <= '0;
      off_q     <= '0;
      err_q     <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      off_q     <= off_d;
      err_q     <= err_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign dmem.dmem_req   = acc;
  assign dmem.dmem_we    = acc & we_q;
  assign dmem.dmem_addr  = acc ? addr_q : '0;
  assign dmem.dmem_be    = acc ? be_q : 4'b0000;
  assign dmem.dmem_wdata = acc ? wdata_q : '0;

  // gated by rst_n so the stall drops immediately on reset even if EX still presents a memory op
  assign stall_o   = rst_n & (acc ? ~dmem.dmem_ready : go);
  assign wb_we_o   = wb_we_q;
  assign wb_rd_o   = wb_rd_q;
  assign wb_data_o = wb_data_q;
  assign lsu_err_o = err_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Randomized self-checking bench for mem_lsu; the bench plays the data memory.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_out = '0, rs2 = '0;
  logic [6:0]  opcode = OPC_NOP;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic        stall, wb_we, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int          n_chk = 0, n_err = 0;

  mem_lsu_if #(.XLEN(32)) dmem ();

  mem_lsu #(.XLEN(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .alu_out_i(alu_out), .opcode_i(opcode),
    .funct3_i(funct3), .rd_i(rd), .rs2_data_i(rs2), .dmem(dmem),
    .stall_o(stall), .wb_we_o(wb_we), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .lsu_err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_nop();
    opcode = OPC_NOP; funct3 = '0; alu_out = '0; rd = '0; rs2 = '0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_req"},   dmem.dmem_req, 0);
    chk({p, "_we"},    dmem.dmem_we, 0);
    chk({p, "_addr"},  dmem.dmem_addr, 0);
    chk({p, "_be"},    dmem.dmem_be, 0);
    chk({p, "_wdata"}, dmem.dmem_wdata, 0);
    chk({p, "_stall"}, stall, 0);
    chk({p, "_wbwe"},  wb_we, 0);
    chk({p, "_wbrd"},  wb_rd, 0);
    chk({p, "_wbdat"}, wb_data, 0);
    chk({p, "_err"},   err, 0);
  endtask

  // Called and returns just after a falling edge; presents one op and checks it to completion.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] r, input int dly,
                        input logic [31:0] rword);
    bit ld, st, ok, wbop;
    int sz, off;
    logic [3:0]  ebe;
    logic [31:0] ewd, ev, sign;
    ld = (op == OPC_LOAD);
    st = (op == OPC_STORE);
    sz = 1 << f3[1:0];
    off = int'(a[1:0]);
    ok = (ld && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) || (st && f3 <= 3'd2);
    ok = ok && ((off % sz) == 0);
    wbop = op inside {OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
    alu_out = a; opcode = op; funct3 = f3; rd = r; rs2 = sd;

    if (!(ld || st)) begin
      dmem.dmem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("alu_stall", stall, 0);
      chk("alu_req", dmem.dmem_req, 0);
      @(negedge clk);
      dmem.dmem_ready = 1'b0;
      chk("alu_wbwe", wb_we, (wbop && r != 0) ? 1 : 0);
      chk("alu_wbrd", wb_rd, r);
      chk("alu_wbdat", wb_data, a);
      chk("alu_err", err, 0);
      set_nop();
      return;
    end

    if (!ok) begin
      #1;
      chk("bad_stall", stall, 0);
      chk("bad_req", dmem.dmem_req, 0);
      @(negedge clk);
      chk("bad_err", err, 1);
      chk("bad_wbwe", wb_we, 0);
      chk("bad_req2", dmem.dmem_req, 0);
      set_nop();
      @(negedge clk);
      chk("bad_errpulse", err, 0);
      return;
    end

    ebe = '0;
    ewd = '0;
    for (int i = 0; i < 4; i++) begin
      if (st && i >= off && i < off + sz) ebe[i] = 1'b1;
      ewd[8*i +: 8] = sd[8*(i % sz) +: 8];
    end
    ev = rword >> (8 * off);
    if (sz < 4) begin
      ev = ev & ((32'd1 << (8 * sz)) - 1);
      sign = 32'd1 << (8 * sz - 1);
      if (f3[2] == 1'b0 && (ev & sign) != 0) ev = ev | ~((32'd1 << (8 * sz)) - 1);
    end

    #1;
    chk("mem_stall_idle", stall, 1);
    chk("mem_req_idle", dmem.dmem_req, 0);
    @(negedge clk);
    chk("mem_bubble", wb_we, 0);
    for (int k = 0; k < TMO; k++) begin
      dmem.dmem_rdata = (k == dly) ? rword : $urandom;
      dmem.dmem_ready = (k == dly);
      #1;
      chk("acc_req", dmem.dmem_req, 1);
      chk("acc_we", dmem.dmem_we, st ? 1 : 0);
      chk("acc_addr", dmem.dmem_addr, a & 32'hFFFF_FFFC);
      chk("acc_be", dmem.dmem_be, ebe);
      if (st) chk("acc_wdata", dmem.dmem_wdata, ewd);
      chk("acc_stall", stall, (k == dly) ? 0 : 1);
      @(negedge clk);
      dmem.dmem_ready = 1'b0;
      if (k == dly) begin
        chk("done_req", dmem.dmem_req, 0);
        chk("done_wbwe", wb_we, (ld && r != 0) ? 1 : 0);
        chk("done_err", err, 0);
        if (ld) begin
          chk("done_wbrd", wb_rd, r);
          chk("done_wbdat", wb_data, ev);
        end
        set_nop();
        return;
      end
    end
    chk("tmo_req", dmem.dmem_req, 0);
    chk("tmo_err", err, 1);
    chk("tmo_wbwe", wb_we, 0);
    set_nop();
    #1;
    chk("tmo_stall", stall, 0);
  endtask

  logic [6:0] opl [10];

  initial begin
    opl = '{OPC_LOAD, OPC_LOAD, OPC_LOAD, OPC_STORE, OPC_STORE,
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_JAL, OPC_NOP};
    dmem.dmem_rdata = '0;
    dmem.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(OPC_OP,    F3_B, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
    run_op(OPC_LOAD,  F3_B, 32'h103,  32'h0, 5'd7, 0, 32'h80FF_0000);
    run_op(OPC_STORE, F3_H, 32'h202,  32'hAAAA_BEEF, 5'd0, 3, 32'h0);
    run_op(OPC_LOAD,  F3_W, 32'h105,  32'h0, 5'd3, 0, 32'h0);
    run_op(OPC_LOAD,  F3_W, 32'h400,  32'h0, 5'd9, 10, 32'h0);
    run_op(OPC_LOAD,  F3_HU, 32'h402, 32'h0, 5'd4, 1, 32'h9876_5432);
    run_op(OPC_STORE, F3_B, 32'h501,  32'h1234_56A5, 5'd0, 0, 32'h0);
    run_op(OPC_LOAD,  F3_W, 32'h600,  32'h0, 5'd0, 0, 32'hDEAD_BEEF);

    // reset while an access is outstanding
    alu_out = 32'h700; opcode = OPC_LOAD; funct3 = F3_W; rd = 5'd6;
    @(negedge clk);
    #1;
    chk("pre_rst_req", dmem.dmem_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    set_nop();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(OPC_OPIMM, F3_B, 32'hCAFE_0001, 32'h0, 5'd12, 0, 32'h0);

    for (int n = 0; n < 120; n++) begin
      run_op(opl[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom_range(0, 31)), int'($urandom_range(0, 5)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
